flags_reg_nbit: RTL and testbench
=================================

FLAGS_REG_NBIT -- requirements
Module: flags_reg_nbit

Interface
REQ-001 The block SHALL use parameter WIDTH, default 8, as the operand and result width in bits (WIDTH >= 2).
REQ-002 The block SHALL use parameter CNTW, default 4, as the error-counter width in bits (CNTW >= 1).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1, is the clock; all state SHALL update on the rising edge only.
REQ-005 Port rst, input, 1, is the synchronous active-high reset.
REQ-006 Port valid, input, 1, is the capture strobe for the current operation.
REQ-007 Port Op, input, 3, is the operation code: 000 = add, 001 = sub, other codes are non-arithmetic.
REQ-008 Port A, input, WIDTH, is operand A.
REQ-009 Port B, input, WIDTH, is operand B.
REQ-010 Port Result, input, WIDTH, is the operation result.
REQ-011 Port Cout, input, 1, is the carry-out of the operation.
REQ-012 Port Error, input, 1, is the operation error (e.g. divide by zero).
REQ-013 Port clr_sticky, input, 1, clears the sticky flags and the error counter.
REQ-014 The live-flag outputs SHALL be Zero, Negative, CarryOut, Overflow and Err, each output, 1, registered.
REQ-015 Port StickyOv, output, 1, is the accumulated overflow flag.
REQ-016 Port StickyErr, output, 1, is the accumulated error flag.
REQ-017 Port ErrCount, output, CNTW, is a saturating count of captured errors.
REQ-018 Port flags_valid, output, 1, is a one-cycle pulse indicating that the flags were updated.

Function
REQ-019 A capture SHALL occur on a rising edge with valid=1 and rst=0; the live flags reflect that cycle's inputs from the next cycle onward (latency 1).
REQ-020 With valid=0, the live flags SHALL hold their previous values.
REQ-021 On capture, Zero SHALL be set to 1 if and only if Result equals 0.
REQ-022 On capture, Negative SHALL be set to Result[WIDTH-1].
REQ-023 On capture, CarryOut SHALL be set to Cout for every Op.
REQ-024 On capture, Err SHALL be set to Error.
REQ-025 On capture with Op=000, Overflow SHALL be set to (A[WIDTH-1] == B[WIDTH-1]) AND (Result[WIDTH-1] != A[WIDTH-1]).
REQ-026 On capture with Op=001, Overflow SHALL be set to (A[WIDTH-1] != B[WIDTH-1]) AND (Result[WIDTH-1] != A[WIDTH-1]).
REQ-027 On capture with any other Op, Overflow SHALL be set to 0.
REQ-028 flags_valid SHALL be 1 in exactly the cycle following each capture and 0 otherwise; back-to-back captures SHALL keep it high continuously.
REQ-029 StickyOv SHALL be set to 1 on any capture whose computed Overflow is 1 and SHALL hold until cleared.
REQ-030 StickyErr SHALL be set to 1 on any capture with Error=1 and SHALL hold until cleared.
REQ-031 ErrCount SHALL increment by 1 on each capture with Error=1 and saturate at 2^CNTW-1 without wrapping.
REQ-032 clr_sticky=1 with no capture SHALL clear StickyOv, StickyErr and ErrCount to 0 on the next edge; live flags are unaffected.
REQ-033 For clr_sticky=1 coincident with a capture, the clear SHALL apply first and the new event second: StickyOv takes the new Overflow, StickyErr takes Error, ErrCount becomes 1 if Error=1 and 0 otherwise.
REQ-034 Live flags SHALL update on a capture regardless of clr_sticky.
REQ-035 Inputs other than clr_sticky SHALL be ignored when valid=0.

Reset
REQ-036 rst=1 at an edge SHALL set Zero, Negative, CarryOut, Overflow, Err, StickyOv, StickyErr, flags_valid to 0 and ErrCount to 0.
REQ-037 rst SHALL dominate valid and clr_sticky; a capture coincident with rst SHALL be discarded.
REQ-038 Reset asserted mid-stream SHALL leave no flag or count from before the reset visible afterward.
REQ-039 The first capture after rst is released SHALL behave as an ordinary capture.

Verification (WIDTH=8, CNTW=2)
REQ-040 The bench SHALL check add overflow: Op=000, A=0x7F, B=0x01, Result=0x80, Cout=0, valid pulse -> next cycle Overflow=1, Negative=1, Zero=0, StickyOv=1, flags_valid=1 for one cycle.
REQ-041 The bench SHALL check sub overflow: Op=001, A=0x80, B=0x01, Result=0x7F, Cout=1 -> Overflow=1, Negative=0, CarryOut=1.
REQ-042 The bench SHALL check the non-arithmetic case: Op=010, A=0x7F, B=0x7F, Result=0x00 -> Zero=1, Overflow=0.
REQ-043 The bench SHALL check sticky hold and clear: a capture per REQ-040, then a clean add (A=0x01, B=0x01, Result=0x02) -> Overflow=0, StickyOv=1; then clr_sticky alone -> StickyOv=0, while live flags still show Result=0x02.
REQ-044 The bench SHALL check counter saturation: 5 captures with Error=1 -> ErrCount=3, Err=1, StickyErr=1; then clr_sticky coincident with an Error=1 capture -> ErrCount=1, StickyErr=1.
REQ-045 The bench SHALL check reset mid-stream: rst=1 coincident with valid=1 and Error=1 after prior flags are set -> next cycle all outputs 0 and ErrCount=0.

Source files
------------

// File: rtl/flags_reg_nbit.sv
// Status-flag register for an N-bit ALU: captures live flags per operation and
// keeps sticky overflow/error flags plus a saturating error counter.
module flags_reg_nbit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Result,
    input  logic             Cout,
    input  logic             Error,
    input  logic             clr_sticky,
    output logic             Zero,
    output logic             Negative,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Err,
    output logic             StickyOv,
    output logic             StickyErr,
    output logic [CNTW-1:0]  ErrCount,
    output logic             flags_valid
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001
    } op_e;

    logic            r_zero;
    logic            r_neg;
    logic            r_carry;
    logic            r_ov;
    logic            r_err;
    logic            r_sticky_ov;
    logic            r_sticky_err;
    logic [CNTW-1:0] r_err_cnt;
    logic            r_flags_valid;

    logic            w_sign_a;
    logic            w_sign_b;
    logic            w_sign_r;
    logic            w_ov;
    logic            w_sticky_ov_next;
    logic            w_sticky_err_next;
    logic [CNTW-1:0] w_cnt_base;
    logic [CNTW-1:0] w_cnt_next;

    always_comb begin
        w_sign_a = A[WIDTH-1];
        w_sign_b = B[WIDTH-1];
        w_sign_r = Result[WIDTH-1];
        w_ov     = 1'b0;
        if (Op == OP_ADD) begin
            w_ov = (w_sign_a == w_sign_b) && (w_sign_r != w_sign_a);
        end else if (Op == OP_SUB) begin
            w_ov = (w_sign_a != w_sign_b) && (w_sign_r != w_sign_a);
        end
    end

    // Clear is applied before the coincident capture's event is accumulated.
    always_comb begin
        w_sticky_ov_next  = clr_sticky ? 1'b0 : r_sticky_ov;
        w_sticky_err_next = clr_sticky ? 1'b0 : r_sticky_err;
        w_cnt_base        = clr_sticky ? '0 : r_err_cnt;
        w_cnt_next        = w_cnt_base;
        if (valid) begin
            w_sticky_ov_next  = w_sticky_ov_next | w_ov;
            w_sticky_err_next = w_sticky_err_next | Error;
            if (Error && !(&w_cnt_base)) begin
                w_cnt_next = w_cnt_base + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero        <= 1'b0;
            r_neg         <= 1'b0;
            r_carry       <= 1'b0;
            r_ov          <= 1'b0;
            r_err         <= 1'b0;
            r_sticky_ov   <= 1'b0;
            r_sticky_err  <= 1'b0;
            r_err_cnt     <= '0;
            r_flags_valid <= 1'b0;
        end else begin
            r_flags_valid <= valid;
            r_sticky_ov   <= w_sticky_ov_next;
            r_sticky_err  <= w_sticky_err_next;
            r_err_cnt     <= w_cnt_next;
            if (valid) begin
                r_zero  <= (Result == '0);
                r_neg   <= w_sign_r;
                r_carry <= Cout;
                r_ov    <= w_ov;
                r_err   <= Error;
            end
        end
    end

    assign Zero        = r_zero;
    assign Negative    = r_neg;
    assign CarryOut    = r_carry;
    assign Overflow    = r_ov;
    assign Err         = r_err;
    assign StickyOv    = r_sticky_ov;
    assign StickyErr   = r_sticky_err;
    assign ErrCount    = r_err_cnt;
    assign flags_valid = r_flags_valid;

endmodule

// File: tb/tb_flags_reg_nbit.sv
// Scoreboard bench for flags_reg_nbit: directed cases plus random traffic
// against a signed-arithmetic reference model.
module tb_flags_reg_nbit;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNTW  = 2;
    localparam int          CMAX  = (1 << CNTW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Result;
    logic             Cout;
    logic             Error;
    logic             clr_sticky;
    logic             Zero;
    logic             Negative;
    logic             CarryOut;
    logic             Overflow;
    logic             Err;
    logic             StickyOv;
    logic             StickyErr;
    logic [CNTW-1:0]  ErrCount;
    logic             flags_valid;

    flags_reg_nbit #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .valid(valid), .Op(Op), .A(A), .B(B),
        .Result(Result), .Cout(Cout), .Error(Error), .clr_sticky(clr_sticky),
        .Zero(Zero), .Negative(Negative), .CarryOut(CarryOut),
        .Overflow(Overflow), .Err(Err), .StickyOv(StickyOv),
        .StickyErr(StickyErr), .ErrCount(ErrCount), .flags_valid(flags_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        bit    z, n, c, ov, err, sov, serr, fv;
        int    cnt;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    task automatic chk(input string tag, input string name, input int act, input int req);
        checks_total++;
        if (act == req) checks_passed++;
        else $display("FAIL %s.%s: got %0d, required %0d", tag, name, act, req);
    endtask

    // Reference model: signed interpretation of operands decides overflow.
    task automatic drive(input string tag, input bit r, input bit v, input int op,
                         input int a, input int b, input int res, input bit co,
                         input bit e, input bit clr);
        int  sa, sb_, sr;
        bit  ov;
        @(negedge clk);
        rst = r; valid = v; Op = op[2:0]; A = a[7:0]; B = b[7:0];
        Result = res[7:0]; Cout = co; Error = e; clr_sticky = clr;
        sa  = int'($signed(A));
        sb_ = int'($signed(B));
        sr  = int'($signed(Result));
        if (op == 0)      ov = ((sa < 0) == (sb_ < 0)) && ((sr < 0) != (sa < 0));
        else if (op == 1) ov = ((sa < 0) != (sb_ < 0)) && ((sr < 0) != (sa < 0));
        else              ov = 1'b0;
        m.tag = tag;
        if (r) begin
            m.z = 0; m.n = 0; m.c = 0; m.ov = 0; m.err = 0;
            m.sov = 0; m.serr = 0; m.fv = 0; m.cnt = 0;
        end else begin
            if (clr) begin m.sov = 0; m.serr = 0; m.cnt = 0; end
            m.fv = v;
            if (v) begin
                m.z   = (res % 256) == 0;
                m.n   = sr < 0;
                m.c   = co;
                m.ov  = ov;
                m.err = e;
                if (ov) m.sov = 1;
                if (e) begin
                    m.serr = 1;
                    if (m.cnt < CMAX) m.cnt++;
                end
            end
        end
        sb.push_back(m);
    endtask

    task automatic idle(input string tag);
        drive(tag, 0, 0, $urandom_range(7), $urandom, $urandom, $urandom, $urandom_range(1), $urandom_range(1), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.tag, "Zero",        int'(Zero),        int'(e.z));
                chk(e.tag, "Negative",    int'(Negative),    int'(e.n));
                chk(e.tag, "CarryOut",    int'(CarryOut),    int'(e.c));
                chk(e.tag, "Overflow",    int'(Overflow),    int'(e.ov));
                chk(e.tag, "Err",         int'(Err),         int'(e.err));
                chk(e.tag, "StickyOv",    int'(StickyOv),    int'(e.sov));
                chk(e.tag, "StickyErr",   int'(StickyErr),   int'(e.serr));
                chk(e.tag, "ErrCount",    int'(ErrCount),    e.cnt);
                chk(e.tag, "flags_valid", int'(flags_valid), int'(e.fv));
            end
        end
    end

    initial begin : stimulus
        int waited;
        rst = 1; valid = 0; Op = 0; A = 0; B = 0; Result = 0;
        Cout = 0; Error = 0; clr_sticky = 0;
        drive("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("reset2", 1, 1, 0, 8'h7F, 1, 8'h80, 0, 1, 1);
        drive("first_cap", 0, 1, 0, 8'h7F, 8'h01, 8'h80, 0, 0, 0);
        drive("add_ov", 0, 1, 0, 8'h7F, 8'h01, 8'h80, 0, 0, 0);
        idle("add_ov_pulse_end");
        drive("sub_ov", 0, 1, 1, 8'h80, 8'h01, 8'h7F, 1, 0, 0);
        drive("nonarith", 0, 1, 2, 8'h7F, 8'h7F, 8'h00, 0, 0, 0);
        drive("clean_add", 0, 1, 0, 8'h01, 8'h01, 8'h02, 0, 0, 0);
        drive("clr_alone", 0, 0, 0, 8'h7F, 8'h01, 8'h80, 1, 1, 1);
        idle("hold");
        for (int i = 0; i < 5; i++)
            drive("err_sat", 0, 1, 3, i, i, 8'h10 + i, 0, 1, 0);
        drive("clr_with_err", 0, 1, 3, 0, 0, 8'h10, 0, 1, 1);
        drive("pre_rst", 0, 1, 0, 8'h7F, 8'h01, 8'h80, 1, 1, 0);
        drive("rst_mid", 1, 1, 0, 8'h7F, 8'h01, 8'h80, 1, 1, 0);
        idle("post_rst");
        drive("cap_after_rst", 0, 1, 1, 8'h00, 8'h01, 8'hFF, 1, 0, 0);
        for (int i = 0; i < 400; i++) begin
            int op;
            op = ($urandom_range(3) != 0) ? $urandom_range(1) : $urandom_range(7);
            drive("rand", ($urandom_range(39) == 0), ($urandom_range(9) < 7), op,
                  $urandom, $urandom,
                  ($urandom_range(7) == 0) ? 0 : $urandom,
                  $urandom_range(1), ($urandom_range(2) == 0), ($urandom_range(7) == 0));
        end
        idle("drain");
        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        checks_total++;
        if (sb.size() == 0) checks_passed++;
        else $display("FAIL drain: got %0d pending, required 0", sb.size());
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
